ahb_bram_ctrl: RTL
==================

AHB_BRAM_CTRL -- requirements
Module: ahb_bram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14: word-address width of the attached block RAM (2**ADDR_WIDTH 32-bit words).
REQ-002 SHALL have ports: HCLK in 1, the single clock; HRESET in 1, asynchronous active-high reset.
REQ-003 SHALL have AHB-Lite slave inputs: HSEL 1, HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HWDATA 32, HREADY 1.
REQ-004 SHALL have AHB-Lite slave outputs: HREADYOUT 1, HRESP 1 (0 OKAY, 1 ERROR), HRDATA 32.
REQ-005 SHALL have RAM write-port outputs: BRAM_ADDRA ADDR_WIDTH, BRAM_WDATA 32, BRAM_WE 4 (byte enables).
REQ-006 SHALL have a RAM read port: BRAM_ADDRB out ADDR_WIDTH; BRAM_RDATA in 32, the RAM's registered output, one HCLK after BRAM_ADDRB.

Function
REQ-007 SHALL accept an address phase only when HSEL & HTRANS[1] & HREADY; IDLE/BUSY transfers SHALL return zero-wait OKAY with no RAM access.
REQ-008 SHALL compute byte lanes: HSIZE 0 -> 4'b0001<<HADDR[1:0]; HSIZE 1 -> 0011 or 1100 by HADDR[1]; HSIZE 2 -> 1111.
REQ-009 SHALL treat HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0 as an error: two-cycle ERROR response (HREADYOUT 0/HRESP 1, then HREADYOUT 1/HRESP 1); no RAM write.
REQ-010 Read: SHALL drive BRAM_ADDRB = HADDR[ADDR_WIDTH+1:2] combinationally in the address phase; HRDATA = BRAM_RDATA in the data phase; zero wait states.
REQ-011 Write: SHALL register the word address and lanes in the address phase; in the data phase it SHALL drive BRAM_ADDRA from the register, BRAM_WDATA=HWDATA and BRAM_WE=lanes. The write commits at the end of the data phase with zero wait states.
REQ-012 BRAM_WE SHALL be 0 in every cycle that is not a write data phase.
REQ-013 Hazard: a read address phase that coincides with a write data phase to the same word SHALL return the post-write word; REQ-020 defines how.
REQ-014 SHALL use states IDLE (no data phase pending), WDATA, RDATA, STALL (stall build only), ERR1, ERR2; each transition SHALL follow from the REQ-009..REQ-013 and REQ-020 rules.
REQ-015 HRDATA SHALL be 32'h0 outside read data phases.
REQ-016 Back-to-back transfers, including write-write and write-read to different words, SHALL complete without wait states.
REQ-017 Address bits above ADDR_WIDTH+1 SHALL be ignored, so accesses wrap modulo the RAM size.

Reset
REQ-018 On HRESET=1, asynchronously: state IDLE, HREADYOUT 1, HRESP 0, BRAM_WE 0, pending address/lanes/hazard registers 0, HRDATA 0.
REQ-019 Reset during a write data phase SHALL suppress that write; reset during STALL or ERR1 SHALL abandon the transfer.

Configuration
REQ-020 Macro AHB_BRAM_BYPASS_EN. Defined: on a hazard, the block registers the write data and lanes, and in the read data phase each HRDATA byte comes from the forwarded write where its lane was set, else from BRAM_RDATA (zero wait). Undefined: on a hazard, the block enters STALL, holds HREADYOUT 0 for one cycle and re-drives BRAM_ADDRB with the registered read address, so the read completes one cycle late with post-write data.

Structure
REQ-021 A shared package SHALL hold the HTRANS/HSIZE/HRESP encodings, the state enumeration and the lane-decode function.
REQ-022 Lane decode and misalignment check SHALL be the sub-module ahb_lane_dec (HADDR[1:0], HSIZE -> lanes, misaligned).

Verification
REQ-023 Word write 0x10=0xDEADBEEF, then an idle cycle, then read 0x10 -> HRDATA 0xDEADBEEF, HREADYOUT always 1.
REQ-024 Byte write 0x13=0xAA over 0x11223344, then read 0x10 -> BRAM_WE 4'b1000 and result 0xAA223344.
REQ-025 Halfword write 0x20 followed immediately by read 0x20 -> bypass build: zero wait; stall build: exactly one HREADYOUT-low cycle; both return the merged word.
REQ-026 Word write at 0x22 -> ERROR two cycles (HRESP 1, HREADYOUT 0 then 1); BRAM_WE stays 0; the word is unchanged.
REQ-027 Assert HRESET during a write data phase to 0x30 -> BRAM_WE 0 and 0x30 unchanged; HREADYOUT 1 immediately.
REQ-028 Write at 0x10000 with ADDR_WIDTH 14 -> the word at 0x0 is written (wrap).

Source files
------------

// File: rtl/ahb_bram_ctrl_pkg.sv
// Shared AHB-Lite encodings, controller state enumeration and byte-lane decode.
// Used by the controller top and its lane decoder.
package ahb_bram_ctrl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RDATA,
        ST_STALL,
        ST_ERR1,
        ST_ERR2
    } state_t;

    typedef struct packed {
        logic       misaligned;
        logic [3:0] lanes;
    } lane_t;

    // Misaligned or oversized transfers report no lanes so they can never write.
    function automatic lane_t lane_decode(input logic [1:0] addr, input logic [2:0] size);
        lane_t r;
        r.misaligned = 1'b0;
        r.lanes      = 4'b0000;
        case (size)
            HSIZE_BYTE: r.lanes = 4'b0001 << addr;
            HSIZE_HALF: begin
                r.lanes      = addr[1] ? 4'b1100 : 4'b0011;
                r.misaligned = addr[0];
            end
            HSIZE_WORD: begin
                r.lanes      = 4'b1111;
                r.misaligned = (addr != 2'b00);
            end
            default: r.misaligned = 1'b1;
        endcase
        if (r.misaligned) begin
            r.lanes = 4'b0000;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_lane_dec.sv
// Byte-lane decode and alignment check for one AHB address phase.
// Purely combinational, no backpressure.
module ahb_lane_dec
    import ahb_bram_ctrl_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] size,
    output logic [3:0] lanes,
    output logic       misaligned
);

    lane_t dec;

    assign dec        = lane_decode(addr, size);
    assign lanes      = dec.lanes;
    assign misaligned = dec.misaligned;

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a dual-port block RAM; zero-wait reads and writes, two-cycle ERROR.
// Read-after-write to the same word stalls one cycle unless AHB_BRAM_BYPASS_EN forwards the write data.
module ahb_bram_ctrl
    import ahb_bram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
    input  logic [31:0]           BRAM_RDATA
);

    state_t                state_q, state_d;
    logic                  hready_q, hready_d;
    logic                  hresp_q, hresp_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [3:0]            lanes_q, lanes_d;
`ifdef AHB_BRAM_BYPASS_EN
    logic [31:0]           fwd_dat_q, fwd_dat_d;
    logic [3:0]            fwd_lanes_q, fwd_lanes_d;
`endif

    logic [3:0]            lanes;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] addr_word;
    logic                  accept;
    logic                  hazard;
    logic                  unused_haddr;

    ahb_lane_dec u_lane_dec (
        .addr       (HADDR[1:0]),
        .size       (HSIZE),
        .lanes      (lanes),
        .misaligned (misaligned)
    );

    // Upper address bits are dropped so accesses wrap modulo the RAM size.
    assign addr_word    = HADDR[ADDR_WIDTH+1:2];
    assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];

    assign accept = HSEL & HREADY
                  & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ))
                  & (state_q != ST_STALL) & (state_q != ST_ERR1);
    assign hazard = accept & ~HWRITE & ~misaligned
                  & (state_q == ST_WDATA) & (addr_word == waddr_q);

    always_comb begin
        state_d = ST_IDLE;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        lanes_d = lanes_q;
`ifdef AHB_BRAM_BYPASS_EN
        fwd_dat_d   = fwd_dat_q;
        fwd_lanes_d = 4'b0000;
`endif
        case (state_q)
            ST_STALL: state_d = ST_RDATA;
            ST_ERR1:  state_d = ST_ERR2;
            default: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d = ST_ERR1;
                    end else if (HWRITE) begin
                        state_d = ST_WDATA;
                        waddr_d = addr_word;
                        lanes_d = lanes;
                    end else begin
                        state_d = ST_RDATA;
                        raddr_d = addr_word;
                        if (hazard) begin
`ifdef AHB_BRAM_BYPASS_EN
                            fwd_dat_d   = HWDATA;
                            fwd_lanes_d = lanes_q;
`else
                            state_d = ST_STALL;
`endif
                        end
                    end
                end
            end
        endcase
        hready_d = (state_d != ST_STALL) && (state_d != ST_ERR1);
        hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            hready_q    <= 1'b1;
            hresp_q     <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            lanes_q     <= '0;
`ifdef AHB_BRAM_BYPASS_EN
            fwd_dat_q   <= '0;
            fwd_lanes_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hready_q    <= hready_d;
            hresp_q     <= hresp_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            lanes_q     <= lanes_d;
`ifdef AHB_BRAM_BYPASS_EN
            fwd_dat_q   <= fwd_dat_d;
            fwd_lanes_q <= fwd_lanes_d;
`endif
        end
    end

    assign HREADYOUT  = hready_q;
    assign HRESP      = hresp_q;
    assign BRAM_ADDRA = waddr_q;
    assign BRAM_WDATA = HWDATA;
    assign BRAM_WE    = (state_q == ST_WDATA) ? lanes_q : 4'b0000;
    // The stall cycle re-reads the word after the write has landed in the RAM.
    assign BRAM_ADDRB = (state_q == ST_STALL) ? raddr_q : addr_word;

    always_comb begin
        HRDATA = 32'h0;
        if (state_q == ST_RDATA) begin
`ifdef AHB_BRAM_BYPASS_EN
            for (int i = 0; i < 4; i++) begin
                HRDATA[8*i +: 8] = fwd_lanes_q[i] ? fwd_dat_q[8*i +: 8] : BRAM_RDATA[8*i +: 8];
            end
`else
            HRDATA = BRAM_RDATA;
`endif
        end
    end

endmodule
